// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one word-addressed data RAM between the core (port 0)
// and the debug/DMA path (port 1). It supports a bounded bus lock and registered responses.
module dmem_arbiter #(
  parameter int DEPTH    = 128,
  parameter int MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        write0,
  input  logic        write1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  output logic        rsp_err0,
  output logic        rsp_err1,
  output logic [31:0] rsp_rdata0,
  output logic [31:0] rsp_rdata1,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic {OPEN, LOCKED} state_t;

  state_t          state;
  logic            owner;
  logic            last_grant;
  logic [CW-1:0]   lock_cnt;

  logic            any_gnt;
  logic            winner;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic            sel_write;
  logic            sel_lock;
  logic            in_range;
  logic            owner_lock;
  logic            lock_last;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (state == LOCKED) begin
        gnt0 = !owner && req0;
        gnt1 = owner && req1;
      end else if (req0 && req1) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign any_gnt    = gnt0 | gnt1;
  assign winner     = gnt1;
  assign sel_addr   = gnt1 ? addr1  : addr0;
  assign sel_wdata  = gnt1 ? wdata1 : wdata0;
  assign sel_write  = gnt1 ? write1 : write0;
  assign sel_lock   = gnt1 ? lock1  : lock0;
  assign in_range   = sel_addr[31:2] < 30'(DEPTH);
  assign owner_lock = owner ? lock1 : lock0;
  assign lock_last  = (lock_cnt + CW'(1)) >= CW'(MAX_LOCK);

  assign mem_address      = any_gnt ? sel_addr  : 32'd0;
  assign mem_write_data   = any_gnt ? sel_wdata : 32'd0;
  assign mem_write_enable = any_gnt & sel_write & in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= OPEN;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      lock_cnt   <= '0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_err0   <= 1'b0;
      rsp_err1   <= 1'b0;
      rsp_rdata0 <= 32'd0;
      rsp_rdata1 <= 32'd0;
    end else begin
      rsp_valid0 <= gnt0;
      rsp_valid1 <= gnt1;
      rsp_err0   <= gnt0 & !in_range;
      rsp_err1   <= gnt1 & !in_range;
      rsp_rdata0 <= (gnt0 && !sel_write && in_range) ? mem_read_data : 32'd0;
      rsp_rdata1 <= (gnt1 && !sel_write && in_range) ? mem_read_data : 32'd0;

      case (state)
        OPEN: begin
          if (any_gnt) begin
            last_grant <= winner;
            // A lock budget of one grant means the opening grant already uses it up.
            if (sel_lock && MAX_LOCK > 1) begin
              state    <= LOCKED;
              owner    <= winner;
              lock_cnt <= CW'(1);
            end
          end
        end
        LOCKED: begin
          // Idle locked cycles also count, so a stalled owner still releases the bus.
          lock_cnt <= lock_cnt + CW'(1);
          if (!owner_lock || lock_last) begin
            state      <= OPEN;
            last_grant <= owner;
            lock_cnt   <= '0;
          end
        end
        default: state <= OPEN;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. It contains a RAM and a behavioural reference model that tracks
// the next-tie preference, the remaining lock budget and the expected responses.
module tb_dmem_arbiter;
  localparam int DEPTH    = 128;
  localparam int MAX_LOCK = 8;
  localparam int AW       = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, write, lock, gnt, rsp_valid, rsp_err;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rsp_rdata [2];
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable;
  logic        ram_init;
  logic [31:0] ram [DEPTH];

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  bit          m_locked;
  int          m_owner, m_prefer, m_budget, last_g;
  logic [31:0] ref_mem [DEPTH];
  logic [1:0]  exp_valid, exp_err;
  logic [31:0] exp_rdata [2];

  dmem_arbiter #(.DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .req1(req[1]), .write0(write[0]), .write1(write[1]),
    .lock0(lock[0]), .lock1(lock[1]), .addr0(addr[0]), .addr1(addr[1]),
    .wdata0(wdata[0]), .wdata1(wdata[1]), .gnt0(gnt[0]), .gnt1(gnt[1]),
    .rsp_valid0(rsp_valid[0]), .rsp_valid1(rsp_valid[1]),
    .rsp_err0(rsp_err[0]), .rsp_err1(rsp_err[1]),
    .rsp_rdata0(rsp_rdata[0]), .rsp_rdata1(rsp_rdata[1]),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // RAM behind the arbiter, combinational read; it is cleared while ram_init is high
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 32'd0;
    end else if (mem_write_enable) begin
      ram[mem_address[2 +: AW]] <= mem_write_data;
    end
  end
  assign mem_read_data = (mem_address[31:2] < DEPTH) ? ram[mem_address[2 +: AW]] : 32'hBAD0_BAD0;

  function automatic int model_grant();
    if (reset) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    if (req[0] && req[1]) return m_prefer;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] gnt_vec(int g);
    if (g < 0) return 2'b00;
    return (g == 0) ? 2'b01 : 2'b10;
  endfunction

  // Advance one clock and update the reference model from the inputs applied in that cycle
  task automatic tick();
    int g;
    logic [29:0] idx;
    bit inr;
    g = model_grant();
    @(posedge clk);
    last_g = g;
    exp_valid = 2'b00;
    exp_err = 2'b00;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    if (reset) begin
      m_locked = 0;
      m_prefer = 0;
    end else begin
      if (g >= 0) begin
        idx = addr[g][31:2];
        inr = idx < DEPTH;
        exp_valid[g] = 1'b1;
        exp_err[g] = !inr;
        if (inr) begin
          if (write[g]) ref_mem[idx] = wdata[g];
          else exp_rdata[g] = ref_mem[idx];
        end
      end
      if (m_locked) begin
        m_budget--;
        if (!lock[m_owner] || m_budget == 0) begin
          m_locked = 0;
          m_prefer = 1 - m_owner;
        end
      end else if (g >= 0) begin
        m_prefer = 1 - g;
        if (lock[g] && MAX_LOCK > 1) begin
          m_locked = 1;
          m_owner = g;
          m_budget = MAX_LOCK - 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    req = 2'b00; write = 2'b00; lock = 2'b00;
    addr[0] = 32'd0; addr[1] = 32'd0; wdata[0] = 32'd0; wdata[1] = 32'd0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 2'b11; write = 2'b11; addr[0] = 32'h8; addr[1] = 32'hC;
    #2;
    tests_run++;
    if (gnt !== 2'b00) begin tests_failed++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    tests_run++;
    if (mem_write_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %b expected 0", mem_write_enable); end
    tests_run++;
    if (mem_address !== 32'd0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h expected 0", mem_address); end
    tick();
    tick();
    reset = 1'b0;
    idle_inputs();
    #2;
    tests_run++;
    if (rsp_valid !== 2'b00 || rsp_err !== 2'b00)
      begin tests_failed++; $display("FAIL reset_rsp: got valid %b err %b expected 00 00", rsp_valid, rsp_err); end
    tests_run++;
    if (rsp_rdata[0] !== 32'd0 || rsp_rdata[1] !== 32'd0)
      begin tests_failed++; $display("FAIL reset_rdata: got %h %h expected 0 0", rsp_rdata[0], rsp_rdata[1]); end
    tick();
  endtask

  task automatic test_single();
    req = 2'b01; write = 2'b01; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    #2;
    tests_run++;
    if (gnt !== 2'b01) begin tests_failed++; $display("FAIL single_store_gnt: got %b expected 01", gnt); end
    tests_run++;
    if (mem_write_enable !== 1'b1 || mem_address !== 32'h10 || mem_write_data !== 32'hDEADBEEF)
      begin tests_failed++; $display("FAIL single_store_bus: got we %b addr %h data %h expected 1 10 deadbeef",
                                     mem_write_enable, mem_address, mem_write_data); end
    tick();
    write = 2'b00;
    #2;
    tests_run++;
    if (gnt !== 2'b01) begin tests_failed++; $display("FAIL single_load_gnt: got %b expected 01", gnt); end
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_rdata[0] !== 32'd0)
      begin tests_failed++; $display("FAIL single_store_rsp: got valid %b rdata %h expected 01 0", rsp_valid, rsp_rdata[0]); end
    tick();
    req = 2'b00;
    #2;
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_rdata[0] !== 32'hDEADBEEF || rsp_rdata[0] !== exp_rdata[0])
      begin tests_failed++; $display("FAIL single_load_rsp: got valid %b rdata %h expected 01 deadbeef", rsp_valid, rsp_rdata[0]); end
    tick();
    #2;
    tests_run++;
    if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL single_rsp_drop: got %b expected 00", rsp_valid); end
    tick();
  endtask

  task automatic test_alternate();
    int cnt0, cnt1;
    logic [1:0] want;
    cnt0 = 0; cnt1 = 0;
    pulse_reset();
    idle_inputs();
    req = 2'b11; addr[0] = 32'h10; addr[1] = 32'h14;
    for (int i = 0; i < 6; i++) begin
      #2;
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      tests_run++;
      if (gnt !== want || gnt !== gnt_vec(model_grant()))
        begin tests_failed++; $display("FAIL alt_gnt[%0d]: got %b expected %b", i, gnt, want); end
      tests_run++;
      if (rsp_rdata[0] !== exp_rdata[0] || rsp_rdata[1] !== exp_rdata[1])
        begin tests_failed++; $display("FAIL alt_rdata[%0d]: got %h %h expected %h %h", i,
                                       rsp_rdata[0], rsp_rdata[1], exp_rdata[0], exp_rdata[1]); end
      cnt0 += int'(rsp_valid[0]);
      cnt1 += int'(rsp_valid[1]);
      tick();
    end
    req = 2'b00;
    #2;
    cnt0 += int'(rsp_valid[0]);
    cnt1 += int'(rsp_valid[1]);
    tests_run++;
    if (cnt0 != 3 || cnt1 != 3)
      begin tests_failed++; $display("FAIL alt_rsp_count: got %0d %0d expected 3 3", cnt0, cnt1); end
    tick();
  endtask

  task automatic test_lock();
    logic [1:0] want;
    pulse_reset();
    idle_inputs();
    req = 2'b11; lock = 2'b01; addr[0] = 32'h20; addr[1] = 32'h24;
    for (int c = 1; c <= MAX_LOCK + 1; c++) begin
      #2;
      want = (c <= MAX_LOCK) ? 2'b01 : 2'b10;
      tests_run++;
      if (gnt !== want || gnt !== gnt_vec(model_grant()))
        begin tests_failed++; $display("FAIL lock_gnt[%0d]: got %b expected %b", c, gnt, want); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_range();
    idle_inputs();
    req = 2'b10; addr[1] = 32'h200;
    #2;
    tests_run++;
    if (gnt !== 2'b10 || mem_write_enable !== 1'b0)
      begin tests_failed++; $display("FAIL range_load_gnt: got gnt %b we %b expected 10 0", gnt, mem_write_enable); end
    tick();
    write = 2'b10; wdata[1] = 32'hCAFEF00D;
    #2;
    tests_run++;
    if (rsp_valid !== 2'b10 || rsp_err !== 2'b10 || rsp_rdata[1] !== 32'd0)
      begin tests_failed++; $display("FAIL range_load_rsp: got valid %b err %b rdata %h expected 10 10 0",
                                     rsp_valid, rsp_err, rsp_rdata[1]); end
    tests_run++;
    if (gnt !== 2'b10 || mem_write_enable !== 1'b0)
      begin tests_failed++; $display("FAIL range_store_we: got gnt %b we %b expected 10 0", gnt, mem_write_enable); end
    tick();
    req = 2'b01; write = 2'b00; addr[0] = 32'h0;
    #2;
    tests_run++;
    if (rsp_err !== 2'b10) begin tests_failed++; $display("FAIL range_store_err: got %b expected 10", rsp_err); end
    tick();
    req = 2'b00;
    #2;
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_err !== 2'b00 || rsp_rdata[0] !== exp_rdata[0])
      begin tests_failed++; $display("FAIL range_ram_intact: got valid %b err %b rdata %h expected 01 00 %h",
                                     rsp_valid, rsp_err, rsp_rdata[0], exp_rdata[0]); end
    tick();
  endtask

  task automatic test_reset_mid_lock();
    pulse_reset();
    idle_inputs();
    req = 2'b11; lock = 2'b01; write = 2'b01; addr[0] = 32'h30; addr[1] = 32'h34; wdata[0] = 32'h1234_5678;
    for (int c = 1; c <= 2; c++) begin
      #2;
      tests_run++;
      if (gnt !== 2'b01) begin tests_failed++; $display("FAIL midlock_gnt[%0d]: got %b expected 01", c, gnt); end
      tick();
    end
    reset = 1'b1;
    wdata[0] = 32'h5555_AAAA;
    #2;
    tests_run++;
    if (gnt !== 2'b00 || mem_write_enable !== 1'b0)
      begin tests_failed++; $display("FAIL midlock_reset_gnt: got gnt %b we %b expected 00 0", gnt, mem_write_enable); end
    tick();
    reset = 1'b0;
    lock = 2'b00; write = 2'b00;
    #2;
    tests_run++;
    if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL midlock_rsp_drop: got %b expected 00", rsp_valid); end
    tests_run++;
    if (gnt !== 2'b01) begin tests_failed++; $display("FAIL midlock_tie: got %b expected 01", gnt); end
    tick();
    req = 2'b00;
    #2;
    tests_run++;
    if (rsp_rdata[0] !== 32'h1234_5678 || rsp_rdata[0] !== exp_rdata[0])
      begin tests_failed++; $display("FAIL midlock_no_write: got %h expected 12345678", rsp_rdata[0]); end
    tick();
  endtask

  task automatic test_random();
    int g, w0, w1;
    logic [1:0] eg;
    logic [31:0] ea;
    logic ewe;
    w0 = 0; w1 = 0;
    pulse_reset();
    idle_inputs();
    for (int n = 0; n < 10000; n++) begin
      #2;
      g = model_grant();
      eg = gnt_vec(g);
      ea = (g >= 0) ? addr[g] : 32'd0;
      ewe = (g >= 0) && write[g] && (addr[g][31:2] < DEPTH);
      tests_run++;
      if (gnt !== eg) begin tests_failed++; $display("FAIL rand_gnt[%0d]: got %b expected %b", n, gnt, eg); end
      tests_run++;
      if (gnt === 2'b11) begin tests_failed++; $display("FAIL rand_two_grants[%0d]: got %b expected at most one", n, gnt); end
      tests_run++;
      if (mem_address !== ea || mem_write_enable !== ewe)
        begin tests_failed++; $display("FAIL rand_bus[%0d]: got addr %h we %b expected %h %b", n, mem_address, mem_write_enable, ea, ewe); end
      tests_run++;
      if (rsp_valid !== exp_valid || rsp_err !== exp_err)
        begin tests_failed++; $display("FAIL rand_rsp[%0d]: got valid %b err %b expected %b %b", n, rsp_valid, rsp_err, exp_valid, exp_err); end
      tests_run++;
      if (rsp_rdata[0] !== exp_rdata[0] || rsp_rdata[1] !== exp_rdata[1])
        begin tests_failed++; $display("FAIL rand_rdata[%0d]: got %h %h expected %h %h", n,
                                       rsp_rdata[0], rsp_rdata[1], exp_rdata[0], exp_rdata[1]); end
      w0 = (req[0] && !gnt[0]) ? w0 + 1 : 0;
      w1 = (req[1] && !gnt[1]) ? w1 + 1 : 0;
      tests_run++;
      if (w0 > MAX_LOCK || w1 > MAX_LOCK)
        begin tests_failed++; $display("FAIL rand_starve[%0d]: got waits %0d %0d expected at most %0d", n, w0, w1, MAX_LOCK); end
      tick();
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || last_g == p) begin
          req[p] = 1'($urandom_range(0, 1));
          write[p] = ($urandom_range(0, 2) == 0);
          if ($urandom_range(0, 9) == 0)
            addr[p] = 32'(($urandom_range(DEPTH, DEPTH + 15) << 2) | $urandom_range(0, 3));
          else
            addr[p] = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
          wdata[p] = $urandom;
        end
        lock[p] = ($urandom_range(0, 3) != 0);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    m_locked = 0; m_owner = 0; m_prefer = 0; m_budget = 0; last_g = -1;
    exp_valid = 2'b00; exp_err = 2'b00; exp_rdata[0] = 32'd0; exp_rdata[1] = 32'd0;
    idle_inputs();
    reset = 1'b1;
    ram_init = 1'b1;
    tick();
    ram_init = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_range();
    test_reset_mid_lock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
